// File: rtl/native_wb_bridge_pkg.sv
// Shared types and helpers for the native-port to Wishbone classic bridge.
package native_wb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS      = 2'd1,
        WAIT_REG = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam int ERR_RDATA = 0;

    function automatic int sel_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/native_wb_bridge_rr_arbiter.sv
// Round-robin arbiter: the pointer marks the highest-priority port and moves past the winner on advance.
module rr_arbiter
    import native_wb_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);
    localparam logic [N-1:0]   ONE   = N'(1);

    logic [IDX_W-1:0] ptr;
    logic             found;

    // Modular add; both operands are below N so one subtraction is enough.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W-1:0] off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        return sum[IDX_W-1:0];
    endfunction

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = wrap_add(ptr, IDX_W'(i));
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant_onehot = found ? (ONE << grant_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= wrap_add(grant_idx, IDX_W'(1));
        end
    end

endmodule

// File: rtl/native_wb_bridge.sv
// Bridges N core-native request ports onto one Wishbone classic master with
// round-robin arbitration, optional registered response and a bus timeout.
module native_wb_bridge
    import native_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_PORTS  = 2,
    parameter int REG_RESP   = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_PORTS-1:0]                      req_en_i,
    input  logic [NUM_PORTS-1:0]                      req_we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]           req_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]           req_wdata_i,
    input  logic [NUM_PORTS*sel_width(DATA_WIDTH)-1:0] req_sel_i,
    output logic [NUM_PORTS-1:0]                      rsp_valid_o,
    output logic                                      rsp_err_o,
    output logic [DATA_WIDTH-1:0]                     rsp_rdata_o,
    output logic                                      wb_cyc_o,
    output logic                                      wb_stb_o,
    output logic                                      wb_we_o,
    output logic [sel_width(DATA_WIDTH)-1:0]          wb_sel_o,
    output logic [ADDR_WIDTH-1:0]                     wb_adr_o,
    output logic [DATA_WIDTH-1:0]                     wb_dat_o,
    input  logic [DATA_WIDTH-1:0]                     wb_dat_i,
    input  logic                                      wb_ack_i,
    input  logic                                      wb_err_i
);

    localparam int SEL_W = sel_width(DATA_WIDTH);
    localparam int IDX_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

    state_t                 state;
    logic [NUM_PORTS-1:0]   arb_req;
    logic [NUM_PORTS-1:0]   arb_onehot;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_advance;
    logic [NUM_PORTS-1:0]   grant_oh_q;
    logic                   bus_cyc;
    logic [CNT_W-1:0]       bus_cnt;
    logic                   bus_timeout;
    logic                   pick_we;
    logic [ADDR_WIDTH-1:0]  pick_adr;
    logic [DATA_WIDTH-1:0]  pick_dat;
    logic [SEL_W-1:0]       pick_sel;
    logic                   term_err_p0;
    logic [DATA_WIDTH-1:0]  term_dat_p0;
    logic                   term_err_p1;
    logic [DATA_WIDTH-1:0]  term_dat_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A port whose completion is being signalled this cycle still holds en; mask it.
    assign arb_req     = req_en_i & ~rsp_valid_o;
    assign arb_advance = (state == IDLE) && (|arb_req);
    assign bus_timeout = (TIMEOUT > 0) && (sat_inc(bus_cnt) == CNT_W'(TIMEOUT));

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (arb_req),
        .advance      (arb_advance),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx)
    );

    always_comb begin
        pick_we  = 1'b0;
        pick_adr = '0;
        pick_dat = '0;
        pick_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (arb_idx == IDX_W'(p)) begin
                pick_we  = req_we_i[p];
                pick_adr = req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                pick_dat = req_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                pick_sel = req_sel_i[p*SEL_W +: SEL_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_oh_q  <= '0;
            bus_cyc     <= 1'b0;
            bus_cnt     <= '0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            term_err_p0 <= 1'b0;
            term_dat_p0 <= '0;
            term_err_p1 <= 1'b0;
            term_dat_p1 <= '0;
            rsp_valid_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= '0;
            unique case (state)
                IDLE: begin
                    if (arb_advance) begin
                        grant_oh_q <= arb_onehot;
                        wb_we_o    <= pick_we;
                        wb_adr_o   <= pick_adr;
                        wb_dat_o   <= pick_dat;
                        wb_sel_o   <= pick_sel;
                        bus_cyc    <= 1'b1;
                        bus_cnt    <= '0;
                        state      <= BUS;
                    end
                end
                // p0 stage: capture termination; a timeout reports as an error.
                BUS: begin
                    if (wb_ack_i || wb_err_i || bus_timeout) begin
                        bus_cyc     <= 1'b0;
                        term_err_p0 <= wb_err_i || !wb_ack_i;
                        term_dat_p0 <= (wb_err_i || !wb_ack_i || wb_we_o) ?
                                       DATA_WIDTH'(ERR_RDATA) : wb_dat_i;
                        state       <= (REG_RESP != 0) ? WAIT_REG : RESP;
                    end else begin
                        bus_cnt <= sat_inc(bus_cnt);
                    end
                end
                // p1 stage: optional extra register toward the core.
                WAIT_REG: begin
                    term_err_p1 <= term_err_p0;
                    term_dat_p1 <= term_dat_p0;
                    state       <= RESP;
                end
                RESP: begin
                    rsp_valid_o <= grant_oh_q;
                    rsp_err_o   <= (REG_RESP != 0) ? term_err_p1 : term_err_p0;
                    rsp_rdata_o <= (REG_RESP != 0) ? term_dat_p1 : term_dat_p0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_cyc_o = bus_cyc;
    assign wb_stb_o = bus_cyc;

endmodule

// File: tb/tb_native_wb_bridge.sv
// Directed bench for native_wb_bridge with Wishbone-side and response-side scoreboards.
`timescale 1ns/1ps
module tb_native_wb_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NP = 2;
    localparam int SW = 4;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic          we;
        logic [SW-1:0] sel;
        logic [DW-1:0] dat;
    } wb_exp_t;

    typedef struct packed {
        logic [NP-1:0] port_oh;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    req_en = '0;
    logic [NP-1:0]    req_en1 = '0;
    logic [NP-1:0]    req_we = '0;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP*DW-1:0] req_wdata = '0;
    logic [NP*SW-1:0] req_sel = '0;

    logic [NP-1:0] rsp_valid0, rsp_valid1;
    logic          rsp_err0, rsp_err1;
    logic [DW-1:0] rsp_rdata0, rsp_rdata1;
    logic          cyc0, stb0, we0, cyc1, stb1, we1;
    logic [SW-1:0] sel0, sel1;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] dato0, dato1;
    logic          ack0, err0, ack1, err1;

    logic [DW-1:0] slv_rdata = '0;
    int            slv_k = 0;
    logic          slv_ack = 1'b1;
    logic          slv_err = 1'b0;
    logic          stray_ack = 1'b0;
    int            stb_cnt0 = 0;
    int            stb_cnt1 = 0;
    int            cyc_n = 0;

    int checks = 0;
    int failures = 0;

    wb_exp_t  exp_wb[$];
    rsp_exp_t exp_rsp[$];
    wb_exp_t  cur_wb;
    logic     cyc_prev = 1'b0;
    int       win_len = 0;
    int       last_win = 0;

    native_wb_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .REG_RESP(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_en_i(req_en), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_sel_i(req_sel),
        .rsp_valid_o(rsp_valid0), .rsp_err_o(rsp_err0), .rsp_rdata_o(rsp_rdata0),
        .wb_cyc_o(cyc0), .wb_stb_o(stb0), .wb_we_o(we0), .wb_sel_o(sel0),
        .wb_adr_o(adr0), .wb_dat_o(dato0), .wb_dat_i(slv_rdata),
        .wb_ack_i(ack0), .wb_err_i(err0)
    );

    native_wb_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .REG_RESP(1), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_en_i(req_en1), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_sel_i(req_sel),
        .rsp_valid_o(rsp_valid1), .rsp_err_o(rsp_err1), .rsp_rdata_o(rsp_rdata1),
        .wb_cyc_o(cyc1), .wb_stb_o(stb1), .wb_we_o(we1), .wb_sel_o(sel1),
        .wb_adr_o(adr1), .wb_dat_o(dato1), .wb_dat_i(slv_rdata),
        .wb_ack_i(ack1), .wb_err_i(err1)
    );

    // Slave model: terminates in the stb cycle numbered slv_k (0 = first stb cycle).
    always @(posedge clk) begin
        cyc_n    <= cyc_n + 1;
        stb_cnt0 <= (cyc0 && stb0) ? stb_cnt0 + 1 : 0;
        stb_cnt1 <= (cyc1 && stb1) ? stb_cnt1 + 1 : 0;
    end

    assign ack0 = (cyc0 && stb0 && (stb_cnt0 == slv_k) && slv_ack) || stray_ack;
    assign err0 = cyc0 && stb0 && (stb_cnt0 == slv_k) && slv_err;
    assign ack1 = cyc1 && stb1 && (stb_cnt1 == slv_k) && slv_ack;
    assign err1 = cyc1 && stb1 && (stb_cnt1 == slv_k) && slv_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid0 != '0) begin
            if (exp_rsp.size() == 0) begin
                chk("rsp_unexpected", rsp_valid0, 0);
            end else begin
                rsp_exp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_port", rsp_valid0, e.port_oh);
                chk("rsp_err", rsp_err0, e.err);
                chk("rsp_rdata", rsp_rdata0, e.rdata);
            end
        end
        if (cyc0 && !cyc_prev) begin
            if (exp_wb.size() == 0) begin
                chk("wb_unexpected_cyc", cyc0, 0);
            end else begin
                cur_wb = exp_wb.pop_front();
                chk("wb_req", {adr0, we0, sel0, dato0}, cur_wb);
            end
            chk("wb_stb", stb0, 1);
            win_len = 1;
        end else if (cyc0) begin
            win_len++;
            chk("wb_hold", {adr0, we0, sel0, dato0, stb0}, {cur_wb, 1'b1});
        end else if (cyc_prev) begin
            last_win = win_len;
        end
        cyc_prev = cyc0;
    end

    task automatic drive_req(input int p, input logic we, input logic [AW-1:0] adr,
                             input logic [DW-1:0] wdata, input logic [SW-1:0] sel);
        req_we[p]            = we;
        req_addr[p*AW +: AW] = adr;
        req_wdata[p*DW +: DW] = wdata;
        req_sel[p*SW +: SW]  = sel;
        req_en[p]            = 1'b1;
        exp_wb.push_back('{adr: adr, we: we, sel: sel, dat: wdata});
    endtask

    task automatic push_rsp(input logic [NP-1:0] oh, input logic err, input logic [DW-1:0] rdata);
        exp_rsp.push_back('{port_oh: oh, err: err, rdata: rdata});
    endtask

    task automatic wait_rsp(input int p, input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid0[p]) begin
                lat = cyc_n - c0;
                req_en[p] = 1'b0;
                break;
            end
        end
        chk($sformatf("wait_rsp_p%0d", p), lat >= 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, lat, lat0, lat1;

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_wb_ctrl", {cyc0, stb0, we0, sel0}, 0);
        chk("rst_wb_data", {adr0, dato0}, 0);
        chk("rst_rsp", {rsp_valid0, rsp_err0, rsp_rdata0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Port 0 read, ack on third stb cycle
        slv_k = 2; slv_ack = 1'b1; slv_err = 1'b0; slv_rdata = 32'hCAFE_BABE;
        c0 = cyc_n;
        drive_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        push_rsp(2'b01, 1'b0, 32'hCAFE_BABE);
        wait_rsp(0, c0, lat);
        chk("t1_latency", lat, 5);
        @(negedge clk);
        chk("t1_valid_one_cycle", rsp_valid0, 0);
        chk("t1_rdata_retained", rsp_rdata0, 32'hCAFE_BABE);

        // Stray ack while idle
        stray_ack = 1'b1;
        @(negedge clk);
        chk("stray_cyc", cyc0, 0);
        @(negedge clk);
        chk("stray_cyc2", cyc0, 0);
        stray_ack = 1'b0;
        @(negedge clk);

        // Port 1 write; inputs scrambled after latching
        slv_k = 1; slv_rdata = 32'hDEAD_BEEF;
        c0 = cyc_n;
        drive_req(1, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011);
        push_rsp(2'b10, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        req_addr[AW +: AW]  = 32'hFFFF_FFFF;
        req_wdata[DW +: DW] = 32'h0;
        req_sel[SW +: SW]   = 4'hC;
        req_we[1]           = 1'b0;
        for (int i = 0; i < 40 && lat >= 0; i++) begin
            @(negedge clk);
            if (rsp_valid0[1]) begin
                lat = cyc_n - c0;
                req_en[1] = 1'b0;
                break;
            end
        end
        chk("t3_latency", lat, 4);
        chk("t3_rdata_zero", rsp_rdata0, 0);
        @(negedge clk);

        // Contention: two simultaneous pairs, both served 0 then 1
        slv_k = 0;
        for (int pair = 0; pair < 2; pair++) begin
            slv_rdata = 32'h1111_0000 + pair;
            c0 = cyc_n;
            drive_req(0, 1'b0, 32'h0000_0100 + pair * 8, 32'hA0, 4'hF);
            drive_req(1, 1'b0, 32'h0000_0104 + pair * 8, 32'hA1, 4'hF);
            push_rsp(2'b01, 1'b0, 32'h1111_0000 + pair);
            push_rsp(2'b10, 1'b0, 32'h1111_0000 + pair);
            wait_rsp(0, c0, lat);
            chk("t2_first_latency", lat, 3);
            chk("t2_port1_waiting", {cyc0, rsp_valid0[1]}, 2'b00);
            wait_rsp(1, c0, lat);
            chk("t2_second_latency", lat, 6);
            @(negedge clk);
        end

        // Timeout with a silent slave, then a normal transaction
        slv_ack = 1'b0; slv_err = 1'b0; slv_rdata = 32'h7777_7777;
        c0 = cyc_n;
        drive_req(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
        push_rsp(2'b01, 1'b1, 32'h0);
        wait_rsp(0, c0, lat);
        chk("t4_latency", lat, 10);
        chk("t4_cyc_window", last_win, 8);
        @(negedge clk);
        slv_ack = 1'b1; slv_k = 0; slv_rdata = 32'h0BAD_F00D;
        c0 = cyc_n;
        drive_req(0, 1'b0, 32'h0000_0024, 32'h0, 4'hF);
        push_rsp(2'b01, 1'b0, 32'h0BAD_F00D);
        wait_rsp(0, c0, lat);
        chk("t4_after_latency", lat, 3);
        @(negedge clk);

        // ack and err together; REG_RESP build responds one cycle later
        slv_k = 1; slv_ack = 1'b1; slv_err = 1'b1; slv_rdata = 32'h55AA_55AA;
        c0 = cyc_n;
        drive_req(0, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
        req_en1[0] = 1'b1;
        push_rsp(2'b01, 1'b1, 32'h0);
        lat0 = -1;
        lat1 = -1;
        for (int i = 0; i < 20 && (lat0 < 0 || lat1 < 0); i++) begin
            @(negedge clk);
            if (lat0 < 0 && rsp_valid0[0]) begin
                lat0 = cyc_n - c0;
                req_en[0] = 1'b0;
            end
            if (lat1 < 0 && rsp_valid1[0]) begin
                lat1 = cyc_n - c0;
                req_en1[0] = 1'b0;
                chk("t5_reg_err", rsp_err1, 1);
                chk("t5_reg_rdata", rsp_rdata1, 0);
            end
        end
        chk("t5_latency_direct", lat0, 4);
        chk("t5_latency_reg", lat1, 5);
        slv_err = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a bus cycle
        slv_ack = 1'b0;
        drive_req(0, 1'b0, 32'h0000_0030, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_bus", cyc0, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_cyc_stb", {cyc0, stb0}, 2'b00);
        chk("t6_async_valid", rsp_valid0, 0);
        req_en = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        slv_ack = 1'b1; slv_k = 0; slv_rdata = 32'h600D_F00D;
        c0 = cyc_n;
        drive_req(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
        push_rsp(2'b10, 1'b0, 32'h600D_F00D);
        wait_rsp(1, c0, lat);
        chk("t6_after_latency", lat, 3);
        @(negedge clk);
        @(negedge clk);

        chk("end_rsp_queue", exp_rsp.size(), 0);
        chk("end_wb_queue", exp_wb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/native_wb_bridge.md
Name: native_wb_bridge

Overview:
- Parametrised bridge from N core-native memory ports (en/we/addr/data/strobe → valid/data) to one Wishbone classic master bus.
- Sits between a core and the Controller's core_* Wishbone interface in processorci_top wrappers.
- Replaces per-core hand-written assign mappings.
- Adds round-robin arbitration, optional registered response (PIPELINED_WISHBONE mode), bus timeout and error reporting.

Parameters:
- DATA_WIDTH, 32, width of data buses; multiple of 8.
- ADDR_WIDTH, 32, width of addresses.
- NUM_PORTS, 2, native requester ports (1..4); port 0 = code, port 1 = data by convention.
- REG_RESP, 0, 1 adds one register stage on ack/err/data toward the core.
- TIMEOUT, 255, cycles in BUS without ack/err before forced error; 0 disables.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_en_i  in  NUM_PORTS  per-port request, level, held until that port's rsp_valid_o.
- req_we_i  in  NUM_PORTS  1 = write.
- req_addr_i  in  NUM_PORTS*ADDR_WIDTH  packed, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata_i  in  NUM_PORTS*DATA_WIDTH  packed write data.
- req_sel_i  in  NUM_PORTS*DATA_WIDTH/8  packed byte strobes.
- rsp_valid_o  out  NUM_PORTS  one-cycle completion pulse per port.
- rsp_err_o  out  1  error flag, qualified by any rsp_valid_o bit.
- rsp_rdata_o  out  DATA_WIDTH  read data, qualified by rsp_valid_o.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone control.
- wb_sel_o  out  DATA_WIDTH/8  byte select.
- wb_adr_o  out  ADDR_WIDTH  address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack_i, wb_err_i  in  1 each  slave termination.

Behaviour:
- Reset state:
  - All outputs 0 immediately on rst_n low, asynchronously.
  - FSM returns to IDLE; timeout counter cleared; RR pointer set so port 0 has highest priority.
- FSM states: IDLE, BUS, WAIT_REG (only when REG_RESP=1), RESP.
- IDLE:
  - If any req_en_i is set, the RR arbiter picks a port.
  - Grant, we, addr, wdata and sel are latched into output registers.
  - Go to BUS; cyc/stb are high from the next cycle.
  - With no request, stay in IDLE with cyc = stb = 0.
- BUS:
  - cyc and stb high; outputs stable.
  - Counter increments each cycle.
  - On wb_ack_i or wb_err_i in cycle N: cyc/stb are 0 at N+1.
  - wb_dat_i and termination kind are captured at N.
  - Next state is RESP (REG_RESP=0) or WAIT_REG (REG_RESP=1).
  - If ack and err arrive together, err wins.
- Timeout:
  - Applies when TIMEOUT>0 and the counter reaches TIMEOUT with no termination.
  - cyc/stb drop; go to RESP with err = 1 and rdata = 0.
- WAIT_REG: one idle cycle, then RESP.
- RESP:
  - rsp_valid_o[grant] = 1 for exactly one cycle.
  - rsp_rdata_o holds the captured data (0 for writes and for errors).
  - rsp_err_o = captured err.
  - Next state IDLE.
- Latency (en rise to valid, slave ack k cycles after stb, k ≥ 0): 2 + k + 1 cycles with REG_RESP=0, one more with REG_RESP=1.
- Requester handshake:
  - req_en_i is not sampled in BUS, WAIT_REG or RESP.
  - A port still asserting en in the cycle after its valid is treated as a new request.
  - Addr, wdata and sel need not stay stable after latching.
- Arbitration:
  - Round-robin; the pointer advances to grant+1 on entry to BUS.
  - Under contention, ports alternate: 0,1,0,1…
  - Only one transaction is outstanding; no pipelined stb.
- Other boundary cases:
  - A stray ack/err in IDLE or RESP is ignored.
  - TIMEOUT counter width is clog2(TIMEOUT+1), saturating.
  - NUM_PORTS=1 degenerates to a fixed grant.
- rsp_rdata_o/rsp_err_o retain their values after RESP until the next RESP.

Decomposition:
- Package native_wb_pkg holds:
  - the state enum (IDLE, BUS, WAIT_REG, RESP);
  - the SEL_WIDTH = DATA_WIDTH/8 function;
  - the clog2 helper;
  - the ERR_RDATA = 0 constant.
- Sub-module rr_arbiter (param N) provides:
  - inputs req[N] and advance; outputs grant_onehot and grant_idx;
  - its own pointer register, using the same async reset.
- FSM, capture registers and timeout counter live in native_wb_bridge.

Test Plan:
- Port 0 read, addr 0x0000_0010, slave acks 2 cycles after stb with 0xCAFEBABE, REG_RESP=0 → one-cycle rsp_valid_o=01, rdata 0xCAFEBABE, err 0; valid 5 cycles after en rise.
- Port 0 and port 1 en in the same cycle, immediate acks → Wishbone serves port 0 then port 1; next simultaneous pair serves 0 then 1 again (alternating pointer); never two cyc windows overlapping.
- Port 1 write, addr 0x8000_0004, wdata 0x12345678, sel 0011 → wb_we=1, wb_sel=0011, wb_dat_o=0x12345678; rsp_valid_o=10, rdata 0.
- TIMEOUT=8, slave never responds → cyc/stb high exactly 8 cycles, then valid with err=1, rdata 0; a later transaction completes normally.
- wb_ack_i and wb_err_i high together on port 0 read → err=1, rdata 0; REG_RESP=1 build shows valid one cycle later than the REG_RESP=0 build.
- rst_n low in BUS mid-transaction → cyc/stb/valid 0 without waiting for clk; after release, a port 1 request is served first-come with port 0 idle.
